// File: rtl/ucode_sequencer.sv
// ucode_sequencer
//   Microcode sequencer. A micro-PC (upc) addresses an external combinational
//   microcode ROM; the returned microword picks the next micro-address
//   (sequential, opcode dispatch, conditional/unconditional jump, or back to
//   the fetch entry) and drives the datapath strobes, selects and immediates.
//   Every microstep takes two cycles: a step phase (0) and a commit phase (1).
//   State advances on the falling edge of clk.
//
// Ports
//   clk        in   system clock (state updates on negedge)
//   reset      in   asynchronous active-low reset
//   instr      in   IR contents
//   urom_data  in   microword at uaddr
//   mem_ready  in   memory handshake, 1 = access complete
//   cond_in    in   datapath condition for conditional microbranches
//   uaddr      out  ROM address (the micro-PC)
//   phase      out  0 = step phase, 1 = commit phase
//   MAR_LOAD, IR_LOAD, MDR_LOAD, REG_LOAD, RAM_LOAD, INCR_PC
//              out  phase-gated load strobes
//   REGR0S, REGR1S, REGWS
//              out  resolved register selects
//   IRimm      out  selected 13-bit immediate
//   ALUfunc    out  ALU function
//   misc       out  pass-through control bits
//   stall      out  holding in commit phase waiting for mem_ready
module ucode_sequencer #(
  parameter int IW         = 16,
  parameter int UAW        = 8,
  parameter int RSW        = 3,
  parameter int FETCH_ADDR = 2,
  parameter int DISP_BASE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IW-1:0]      instr,
  input  logic [UAW+31:0]    urom_data,
  input  logic               mem_ready,
  input  logic               cond_in,
  output logic [UAW-1:0]     uaddr,
  output logic               phase,
  output logic               MAR_LOAD,
  output logic               IR_LOAD,
  output logic               MDR_LOAD,
  output logic               REG_LOAD,
  output logic               RAM_LOAD,
  output logic               INCR_PC,
  output logic [RSW-1:0]     REGR0S,
  output logic [RSW-1:0]     REGR1S,
  output logic [RSW-1:0]     REGWS,
  output logic [12:0]        IRimm,
  output logic [2:0]         ALUfunc,
  output logic [3:0]         misc,
  output logic               stall
);

  typedef enum logic [1:0] {
    NXT_SEQ      = 2'd0,
    NXT_DISPATCH = 2'd1,
    NXT_JUMP     = 2'd2,
    NXT_FETCH    = 2'd3
  } nxt_t;

  typedef enum logic {
    PH_STEP   = 1'b0,
    PH_COMMIT = 1'b1
  } phase_t;

  // Register-select resolution: codes 8..11 pull a field out of the IR,
  // anything else is a literal register number.
  function automatic logic [RSW-1:0] reg_sel(input logic [3:0] code,
                                             input logic [8:0] ir);
    case (code)
      4'd8:    reg_sel = RSW'(ir[8:6]);
      4'd9:    reg_sel = RSW'(ir[5:3]);
      4'd10:   reg_sel = RSW'(ir[2:0]);
      4'd11:   reg_sel = RSW'({1'b0, ir[1:0]});
      default: reg_sel = RSW'(code);
    endcase
  endfunction

  // Immediate selection. Code 3 is a small signed table of powers of two
  // indexed by IR[8:6], used for stack/pointer adjustments.
  function automatic logic [12:0] imm_sel(input logic [1:0]  sel,
                                          input logic [12:0] ir);
    logic signed [12:0] tbl;
    case (ir[8:6])
      3'd0:    tbl = 13'sd1;
      3'd1:    tbl = 13'sd2;
      3'd2:    tbl = 13'sd4;
      3'd3:    tbl = 13'sd8;
      3'd4:    tbl = -13'sd8;
      3'd5:    tbl = -13'sd4;
      3'd6:    tbl = -13'sd2;
      default: tbl = -13'sd1;
    endcase
    case (sel)
      2'd0:    imm_sel = {6'b0, ir[8:2]};
      2'd1:    imm_sel = {3'b0, ir[12:3]};
      2'd2:    imm_sel = ir;
      default: imm_sel = tbl;
    endcase
  endfunction

  logic [UAW-1:0] upc;
  phase_t         ph;
  logic           run;

  // Microword fields
  logic [UAW-1:0] target;
  nxt_t           nxt_sel;
  logic           wait_en;
  logic           cond_en;
  logic [5:0]     strobe_bits;
  logic           unused_rsvd;

  assign target      = urom_data[UAW+31:32];
  assign nxt_sel     = nxt_t'(urom_data[31:30]);
  assign wait_en     = urom_data[29];
  assign cond_en     = urom_data[28];
  assign strobe_bits = urom_data[13:8];
  assign unused_rsvd = urom_data[4];

  // Long opcodes (IR[15]=1) use six bits, short opcodes use two.
  logic [5:0]     opcode;
  logic [UAW-1:0] upc_inc;
  logic [UAW-1:0] upc_nxt;

  assign opcode  = instr[15] ? instr[14:9] : {4'b0, instr[14:13]};
  assign upc_inc = upc + UAW'(1);

  always_comb begin
    upc_nxt = upc_inc;
    case (nxt_sel)
      NXT_SEQ:      upc_nxt = upc_inc;
      NXT_DISPATCH: upc_nxt = UAW'(DISP_BASE) + UAW'(opcode);
      NXT_JUMP:     upc_nxt = (!cond_en || cond_in) ? target : upc_inc;
      NXT_FETCH:    upc_nxt = UAW'(FETCH_ADDR);
      default:      upc_nxt = upc_inc;
    endcase
  end

  // A waiting microstep parks in the commit phase until memory answers.
  assign stall = (ph == PH_COMMIT) & wait_en & ~mem_ready;

  // Sequencer state: run goes high on the first falling edge out of reset,
  // so the step phase that precedes it never emits a strobe.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      upc <= UAW'(FETCH_ADDR);
      ph  <= PH_STEP;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      if (ph == PH_STEP) begin
        ph <= PH_COMMIT;
      end else if (!stall) begin
        ph  <= PH_STEP;
        upc <= upc_nxt;
      end
    end
  end

  assign uaddr = upc;
  assign phase = (ph == PH_COMMIT);

  // Address/data register loads happen in the commit phase; IR, register
  // file, RAM and PC updates happen in the step phase.
  assign MAR_LOAD = run &  phase & strobe_bits[5];
  assign IR_LOAD  = run & ~phase & strobe_bits[4];
  assign MDR_LOAD = run &  phase & strobe_bits[3];
  assign REG_LOAD = run & ~phase & strobe_bits[2];
  assign RAM_LOAD = run & ~phase & strobe_bits[1];
  assign INCR_PC  = run & ~phase & strobe_bits[0];

  assign REGR0S  = reg_sel(urom_data[27:24], instr[8:0]);
  assign REGR1S  = reg_sel(urom_data[23:20], instr[8:0]);
  assign REGWS   = reg_sel(urom_data[19:16], instr[8:0]);
  assign IRimm   = imm_sel(urom_data[15:14], instr[12:0]);
  assign ALUfunc = urom_data[7:5];
  assign misc    = urom_data[3:0];

endmodule

// File: tb/tb_ucode_sequencer.sv
module tb_ucode_sequencer;

  localparam int SEQ = 0, DISP = 1, JMP = 2, FET = 3;
  localparam logic [5:0] S_MAR = 6'b100000, S_MDR = 6'b001000;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        mem_ready = 1'b1;
  logic        cond_in = 1'b0;
  logic [39:0] urom_data;

  logic [7:0]  uaddr;
  logic        phase, stall;
  logic        MAR_LOAD, IR_LOAD, MDR_LOAD, REG_LOAD, RAM_LOAD, INCR_PC;
  logic [2:0]  REGR0S, REGR1S, REGWS;
  logic [12:0] IRimm;
  logic [2:0]  ALUfunc;
  logic [3:0]  misc;

  logic [39:0] rom [256];
  assign urom_data = rom[uaddr];

  ucode_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .urom_data(urom_data),
    .mem_ready(mem_ready), .cond_in(cond_in), .uaddr(uaddr), .phase(phase),
    .MAR_LOAD(MAR_LOAD), .IR_LOAD(IR_LOAD), .MDR_LOAD(MDR_LOAD),
    .REG_LOAD(REG_LOAD), .RAM_LOAD(RAM_LOAD), .INCR_PC(INCR_PC),
    .REGR0S(REGR0S), .REGR1S(REGR1S), .REGWS(REGWS), .IRimm(IRimm),
    .ALUfunc(ALUfunc), .misc(misc), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: micro-PC, phase and run flag.
  int m_upc, m_phase, m_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] mw(input int tgt, input int nxt, input int wt,
                                     input int ce, input int sel12, input int imms,
                                     input logic [5:0] stb, input int alu, input int msc);
    mw = {8'(tgt), 2'(nxt), 1'(wt), 1'(ce), 12'(sel12), 2'(imms), stb,
          3'(alu), 1'b0, 4'(msc)};
  endfunction

  function automatic int ref_sel(input int code, input int ir);
    case (code)
      8:       ref_sel = (ir >> 6) % 8;
      9:       ref_sel = (ir >> 3) % 8;
      10:      ref_sel = ir % 8;
      11:      ref_sel = ir % 4;
      default: ref_sel = code % 8;
    endcase
  endfunction

  function automatic int ref_imm(input int s, input int ir);
    int tbl [8] = '{1, 2, 4, 8, -8, -4, -2, -1};
    case (s)
      0:       ref_imm = (ir >> 2) % 128;
      1:       ref_imm = (ir >> 3) % 1024;
      2:       ref_imm = ir % 8192;
      default: ref_imm = tbl[(ir >> 6) % 8] & 32'h1FFF;
    endcase
  endfunction

  task automatic model_reset();
    m_upc = 2; m_phase = 0; m_run = 0;
  endtask

  // One falling edge of the reference machine.
  task automatic model_step();
    logic [39:0] w;
    int op, nx;
    if (reset === 1'b0) return;
    w = rom[m_upc];
    m_run = 1;
    if (m_phase == 0) begin
      m_phase = 1;
      return;
    end
    if (w[29] && !mem_ready) return;
    op = instr[15] ? int'(instr >> 9) % 64 : int'(instr >> 13) % 4;
    case (int'(w[31:30]))
      SEQ:     nx = (m_upc + 1) % 256;
      DISP:    nx = op % 256;
      JMP:     nx = (!w[28] || cond_in) ? int'(w[39:32]) : (m_upc + 1) % 256;
      default: nx = 2;
    endcase
    m_upc = nx;
    m_phase = 0;
  endtask

  task automatic check_all();
    logic [39:0] w;
    int ph, rn, ir;
    w  = rom[m_upc];
    ph = m_phase;
    rn = m_run;
    ir = int'(instr);
    chk("uaddr", 32'(uaddr), m_upc);
    chk("phase", 32'(phase), ph);
    chk("stall", 32'(stall), (ph == 1 && w[29] && !mem_ready) ? 1 : 0);
    chk("MAR_LOAD", 32'(MAR_LOAD), (rn == 1 && ph == 1 && w[13]) ? 1 : 0);
    chk("IR_LOAD",  32'(IR_LOAD),  (rn == 1 && ph == 0 && w[12]) ? 1 : 0);
    chk("MDR_LOAD", 32'(MDR_LOAD), (rn == 1 && ph == 1 && w[11]) ? 1 : 0);
    chk("REG_LOAD", 32'(REG_LOAD), (rn == 1 && ph == 0 && w[10]) ? 1 : 0);
    chk("RAM_LOAD", 32'(RAM_LOAD), (rn == 1 && ph == 0 && w[9])  ? 1 : 0);
    chk("INCR_PC",  32'(INCR_PC),  (rn == 1 && ph == 0 && w[8])  ? 1 : 0);
    chk("REGR0S", 32'(REGR0S), ref_sel(int'(w[27:24]), ir));
    chk("REGR1S", 32'(REGR1S), ref_sel(int'(w[23:20]), ir));
    chk("REGWS",  32'(REGWS),  ref_sel(int'(w[19:16]), ir));
    chk("IRimm",  32'(IRimm),  ref_imm(int'(w[15:14]), ir));
    chk("ALUfunc", 32'(ALUfunc), int'(w[7:5]));
    chk("misc",   32'(misc),   int'(w[3:0]));
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    settle();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    settle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[2]     = mw(0, SEQ, 0, 0, 0, 0, S_MAR, 0, 0);
    rom[3]     = mw(0, DISP, 0, 0, 0, 0, 6'b0, 0, 0);
    rom[8'h11] = mw(0, FET, 0, 0, 0, 0, 6'b0, 0, 0);

    // Reset, release, first step and dispatch
    #2;
    do_reset();
    chk("rst_uaddr", 32'(uaddr), 2);
    chk("rst_mar", 32'(MAR_LOAD), 0);
    release_reset();
    chk("mar_run0", 32'(MAR_LOAD), 0);
    step(1);
    chk("mar_ph1", 32'(MAR_LOAD), 1);
    step(1);
    chk("seq_adv", 32'(uaddr), 3);
    instr = 16'hA200;
    settle();
    step(2);
    chk("disp_long", 32'(uaddr), 'h11);
    step(4);
    instr = 16'h4000;
    settle();
    step(2);
    chk("disp_short", 32'(uaddr), 2);

    // Memory stall, conditional jumps, immediates
    do_reset();
    rom[2]     = mw('h20, JMP, 0, 0, 0, 0, 6'b0, 0, 0);
    rom[8'h20] = mw(0, SEQ, 1, 0, 0, 0, S_MDR, 0, 0);
    rom[8'h21] = mw('h40, JMP, 0, 1, 0, 0, 6'b0, 0, 0);
    rom[8'h22] = mw('h40, JMP, 0, 0, 0, 0, 6'b0, 0, 0);
    rom[8'h40] = mw(0, FET, 0, 0, 'h900, 3, 6'b0, 5, 9);
    mem_ready = 1'b0;
    release_reset();
    step(2);
    chk("stall_ph0_mdr", 32'(MDR_LOAD), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_hi", 32'(stall), 1);
      chk("stall_upc", 32'(uaddr), 'h20);
      chk("stall_mdr", 32'(MDR_LOAD), 1);
    end
    mem_ready = 1'b1;
    settle();
    chk("stall_release", 32'(stall), 0);
    step(1);
    chk("stall_adv", 32'(uaddr), 'h21);
    cond_in = 1'b1;
    settle();
    step(2);
    chk("jmp_taken", 32'(uaddr), 'h40);
    instr = 16'h01E8;
    settle();
    chk("imm_m1", 32'(IRimm), 'h1FFF);
    chk("r0sel_9", 32'(REGR0S), 5);
    instr = 16'h00E8;
    settle();
    chk("imm_8", 32'(IRimm), 8);
    cond_in = 1'b0;
    settle();
    step(6);
    chk("jmp_back", 32'(uaddr), 'h21);
    step(2);
    chk("jmp_not_taken", 32'(uaddr), 'h22);
    step(2);
    chk("jmp_uncond", 32'(uaddr), 'h40);

    // Micro-PC wrap
    do_reset();
    rom[2]     = mw('hFF, JMP, 0, 0, 0, 0, 6'b0, 0, 0);
    rom[8'hFF] = mw(0, SEQ, 0, 0, 0, 0, S_MAR, 0, 0);
    release_reset();
    step(2);
    chk("at_ff", 32'(uaddr), 'hFF);
    step(2);
    chk("wrap", 32'(uaddr), 0);

    // Reset in the middle of a stall
    do_reset();
    rom[2] = mw('h20, JMP, 0, 0, 0, 0, 6'b0, 0, 0);
    mem_ready = 1'b0;
    release_reset();
    step(3);
    chk("pre_rst_stall", 32'(stall), 1);
    do_reset();
    chk("rst_stall_uaddr", 32'(uaddr), 2);
    chk("rst_stall_phase", 32'(phase), 0);
    chk("rst_stall_stall", 32'(stall), 0);
    chk("rst_stall_strobes",
        32'({MAR_LOAD, IR_LOAD, MDR_LOAD, REG_LOAD, RAM_LOAD, INCR_PC}), 0);
    step(2);
    release_reset();
    step(4);

    // Randomized microprograms and inputs
    for (int i = 0; i < 256; i++) begin
      rom[i] = {8'($urandom), 32'($urandom)};
      rom[i][29] = ($urandom_range(3) == 0);
    end
    for (int c = 0; c < 3000; c++) begin
      instr     = 16'($urandom);
      mem_ready = ($urandom_range(3) != 0);
      cond_in   = 1'($urandom);
      if (reset == 1'b0) begin
        reset = 1'b1;
      end else if ($urandom_range(99) == 0) begin
        reset = 1'b0;
        model_reset();
      end
      settle();
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Parametrised microcode sequencer replacing the fixed 8-state FETCH..EXECM decoder.
- Holds a micro-PC (upc) that addresses an external combinational microcode ROM. The microword selects the next address: sequential, opcode dispatch, jump/conditional jump, or return to fetch.
- Adds what the fixed decoder lacks: variable-length microprograms, a memory-ready stall, conditional microbranches, and sign-extended IR immediates.
- Sits between the IR/ROM and the datapath muxes and strobes.

Parameters:
- IW, 16: instruction width; opcode and field positions below assume IW=16.
- UAW, 8: micro-address width; ROM depth is 2**UAW.
- RSW, 3: register-select width.
- FETCH_ADDR, 2: microprogram entry used after reset and on nxt=FETCH.
- DISP_BASE, 0: dispatch base; the target is DISP_BASE+opcode, modulo 2**UAW.

Ports:
- clk  in  1  system clock; all state updates on negedge clk.
- reset  in  1  asynchronous, active-low reset.
- instr  in  IW  current IR contents.
- urom_data  in  UAW+32  microword at uaddr (combinational ROM).
- mem_ready  in  1  memory handshake; 1 = access complete.
- cond_in  in  1  datapath condition result.
- uaddr  out  UAW  ROM address; equals upc.
- phase  out  1  0 = step phase, 1 = commit (M) phase.
- MAR_LOAD, IR_LOAD, MDR_LOAD, REG_LOAD, RAM_LOAD, INCR_PC  out  1 each  gated load strobes.
- REGR0S, REGR1S, REGWS  out  RSW each  resolved register selects.
- IRimm  out  13  selected immediate.
- ALUfunc  out  3  ALU function.
- misc  out  4  pass-through control (MDRS/OP0S/OP1S encodings).
- stall  out  1  sequencer is holding on mem_ready.

Behaviour:
- Microword fields:
  - [UAW+31:32] target
  - [31:30] nxt: 0 SEQ, 1 DISPATCH, 2 JUMP, 3 FETCH
  - [29] wait
  - [28] cond_en
  - [27:24] r0sel
  - [23:20] r1sel
  - [19:16] wsel
  - [15:14] imms
  - [13:8] strobes MAR, IR, MDR, REG, RAM, INCR_PC
  - [7:5] alu
  - [4] reserved
  - [3:0] misc
- Reset (reset=0, asynchronous):
  - upc=FETCH_ADDR, phase=0, run=0, stall=0.
  - All six strobes are forced 0 while run=0.
  - run sets on the first negedge after reset deasserts. The first non-zero strobe can therefore appear no earlier than the first phase-1 cycle.
- Each microstep takes two cycles: phase 0, then phase 1.
  - MAR_LOAD and MDR_LOAD assert only in phase 1.
  - IR_LOAD, REG_LOAD, RAM_LOAD and INCR_PC assert only in phase 0.
  - Every strobe is also ANDed with its microword bit and with run.
  - Selects, IRimm, ALUfunc and misc follow urom_data combinationally in both phases.
- Phase 0 -> 1 is unconditional.
- Phase 1 -> next step:
  - If wait=1 and mem_ready=0: hold upc and phase=1; stall=1 combinationally; phase-1 strobes stay asserted.
  - Otherwise phase<=0 and upc<=next.
- Next-address rules:
  - SEQ: upc+1, wrapping from 2**UAW-1 to 0.
  - DISPATCH: DISP_BASE+opcode. opcode = instr[15] ? instr[14:9] : {4'b0, instr[14:13]}, zero-extended to UAW.
  - JUMP: if cond_en=0, jump to target. If cond_en=1, go to target when cond_in=1, else upc+1. cond_in is sampled at the same negedge that leaves phase 1.
  - FETCH: FETCH_ADDR.
- Register-select decode (r0sel, r1sel, wsel):
  - 8 -> instr[8:6]
  - 9 -> instr[5:3]
  - 10 -> instr[2:0]
  - 11 -> {0, instr[1:0]}
  - any other code -> code[RSW-1:0]
  - Instruction fields are zero-extended when RSW>3.
- Immediates, by imms:
  - 0: imm7 = instr[8:2], zero-extended.
  - 1: imm10 = instr[12:3], zero-extended.
  - 2: imm13 = instr[12:0].
  - 3: IR table on instr[8:6] = {1, 2, 4, 8, -8, -4, -2, -1}, sign-extended to 13 bits (e.g. -1 = 13'h1FFF).
- Reset asserted mid-step, including during a stall: immediate return to reset values; no strobe glitches out afterward.
- No latches: every combinational output has a default assignment.

Test Plan:
- Reset then release; ROM[2] has nxt=SEQ and MAR=1, ROM[3] has nxt=DISPATCH.
  - Required: uaddr=2.
  - MAR_LOAD=0 until run=1, then high only in phase 1.
  - uaddr advances to 3 after 2 cycles.
- instr=16'hA200 (long opcode 0x11) dispatched from ROM[3] -> uaddr=0x11. instr=16'h4000 (short opcode 2) -> uaddr=2.
- Step with wait=1 and MDR=1, mem_ready held low 3 cycles.
  - Required: stall=1, upc frozen, MDR_LOAD high throughout.
  - Advances on the negedge after mem_ready=1.
- JUMP with cond_en=1, target=0x40: cond_in=1 -> uaddr=0x40; cond_in=0 -> uaddr=upc+1. Same test with cond_en=0 -> 0x40 regardless of cond_in.
- imms=3: instr[8:6]=7 -> IRimm=13'h1FFF; instr[8:6]=3 -> IRimm=8. r0sel=9 with instr[5:3]=5 -> REGR0S=5.
- upc=0xFF with SEQ -> 0x00. reset pulsed low during a stall -> uaddr=2, phase=0, stall=0, all strobes 0.
